// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding (also used by the APB slave) and
// default bus widths / timeout for the APB master.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_ADDR_W      = 8;
  localparam int APB_DATA_W      = 8;
  localparam int APB_TIMEOUT_CYC = 16;

endpackage

// File: rtl/apb_master.sv
// Command/response to APB bridge with pready wait-state handling.
// Optional ACCESS-phase timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              accept_s;
  logic              complete_s;
  logic              abort_s;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Abort on the ACCESS cycle that would be the TIMEOUT_CYC-th stalled one.
  assign abort_s = (state_q == APB_ACCESS) && !pready && (cnt_q == CNT_LAST);

  // Stall counter: cleared while in SETUP, i.e. on entry to ACCESS.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == APB_SETUP) begin
      cnt_d = '0;
    end else if ((state_q == APB_ACCESS) && !pready && !abort_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYC > 0);
  assign abort_s          = 1'b0;
`endif

  assign cmd_ready  = (state_q == APB_IDLE) || ((state_q == APB_ACCESS) && pready);
  assign accept_s   = cmd_valid && cmd_ready;
  assign complete_s = (state_q == APB_ACCESS) && pready;

  // Next-state, request capture and response generation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_IDLE: begin
        if (cmd_valid) state_d = APB_SETUP;
        else           state_d = APB_IDLE;
      end
      APB_SETUP: begin
        state_d = APB_ACCESS;
      end
      APB_ACCESS: begin
        if (pready)       state_d = cmd_valid ? APB_SETUP : APB_IDLE;
        else if (abort_s) state_d = APB_IDLE;
        else              state_d = APB_ACCESS;
      end
      default: begin
        state_d = APB_IDLE;
      end
    endcase

    psel_d    = (state_d != APB_IDLE);
    penable_d = (state_d == APB_ACCESS);

    if (accept_s) begin
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_wdata;
    end else begin
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
    end

    rsp_valid_d = complete_s || abort_s;
    rsp_err_d   = abort_s;
    if (abort_s) begin
      rsp_rdata_d = '0;
    end else if (complete_s && !pwrite_q) begin
      rsp_rdata_d = prdata;
    end else begin
      rsp_rdata_d = rsp_rdata_q;
    end
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= APB_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
